// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI-Lite response codes and register-file FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Response code for a decoded access: in-range words are OKAY, others SLVERR.
    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_strb_merge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_strb_merge
//  Description : Combinational byte-strobe merge of an old word and a new word.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    // Each byte lane takes the new byte when its strobe is set.
    for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
        assign merged[b*8 +: 8] = strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regfile
//  Description : AXI-Lite slave exposing NUM_REGS byte-strobed registers with
//                independent single-outstanding read and write paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_aw_addr,
    input  logic                           s_aw_valid,
    output logic                           s_aw_ready,
    input  logic [DATA_WIDTH-1:0]          s_w_data,
    input  logic [DATA_WIDTH/8-1:0]        s_w_strb,
    input  logic                           s_w_valid,
    output logic                           s_w_ready,
    output logic [1:0]                     s_b_resp,
    output logic                           s_b_valid,
    input  logic                           s_b_ready,
    input  logic [ADDR_WIDTH-1:0]          s_ar_addr,
    input  logic                           s_ar_valid,
    output logic                           s_ar_ready,
    output logic [DATA_WIDTH-1:0]          s_r_data,
    output logic [1:0]                     s_r_resp,
    output logic                           s_r_valid,
    input  logic                           s_r_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W  = ADDR_WIDTH - OFFS;

    wr_state_e                    wr_state_q, wr_state_d;
    logic                         aw_held_q, aw_held_d;
    logic [IDX_W-1:0]             aw_idx_q, aw_idx_d;
    logic                         w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]        w_data_q, w_data_d;
    logic [STRB_W-1:0]            w_strb_q, w_strb_d;
    logic [1:0]                   b_resp_q, b_resp_d;
    logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

    rd_state_e                    rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0]        r_data_q, r_data_d;
    logic [1:0]                   r_resp_q, r_resp_d;

    logic [IDX_W-1:0]             ar_idx;
    logic                         aw_in_range;
    logic                         ar_in_range;
    logic [DATA_WIDTH-1:0]        old_word;
    logic [DATA_WIDTH-1:0]        merged_word;

    assign ar_idx      = s_ar_addr[ADDR_WIDTH-1:OFFS];
    assign aw_in_range = aw_idx_q < IDX_W'(NUM_REGS);
    assign ar_in_range = ar_idx < IDX_W'(NUM_REGS);

    // Select the current contents of the addressed write target for merging.
    always_comb begin
        old_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx_q == IDX_W'(i)) old_word = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    axi_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_strb_merge (
        .old_data (old_word),
        .new_data (w_data_q),
        .strb     (w_strb_q),
        .merged   (merged_word)
    );

    // Write path: collect AW and W independently, commit once both are held, then respond.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_resp_d   = b_resp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    // Out-of-range indices match no register, so SLVERR writes touch nothing.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (aw_idx_q == IDX_W'(i)) begin
                            regs_d[i*DATA_WIDTH +: DATA_WIDTH] = merged_word;
                            wr_pulse_d[i] = 1'b1;
                        end
                    end
                    b_resp_d   = resp_for(aw_in_range);
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    if (!aw_held_q && s_aw_valid) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = s_aw_addr[ADDR_WIDTH-1:OFFS];
                    end
                    if (!w_held_q && s_w_valid) begin
                        w_held_d = 1'b1;
                        w_data_d = s_w_data;
                        w_strb_d = s_w_strb;
                    end
                end
            end
            W_RESP: begin
                if (s_b_ready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path: sample the addressed register on AR, hold the response until accepted.
    always_comb begin
        rd_state_d = rd_state_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (s_ar_valid) begin
                    r_data_d = '0;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (ar_idx == IDX_W'(i)) r_data_d = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    r_resp_d   = resp_for(ar_in_range);
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_r_ready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_resp_q   <= RESP_OKAY;
            wr_pulse_q <= '0;
            regs_q     <= '0;
            rd_state_q <= R_IDLE;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_resp_q   <= b_resp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign s_aw_ready = (wr_state_q == W_IDLE) && !aw_held_q;
    assign s_w_ready  = (wr_state_q == W_IDLE) && !w_held_q;
    assign s_b_valid  = (wr_state_q == W_RESP);
    assign s_b_resp   = b_resp_q;
    assign s_ar_ready = (rd_state_q == R_IDLE);
    assign s_r_valid  = (rd_state_q == R_RESP);
    assign s_r_data   = r_data_q;
    assign s_r_resp   = r_resp_q;
    assign reg_q      = regs_q;
    assign wr_pulse   = wr_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_regfile
//  Description : Self-checking bench for axi_lite_regfile: transaction-level
//                reference model, per-cycle compare, directed and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_aw_addr;
    logic          s_aw_valid, s_aw_ready;
    logic [31:0]   s_w_data;
    logic [3:0]    s_w_strb;
    logic          s_w_valid, s_w_ready;
    logic [1:0]    s_b_resp;
    logic          s_b_valid, s_b_ready;
    logic [31:0]   s_ar_addr;
    logic          s_ar_valid, s_ar_ready;
    logic [31:0]   s_r_data;
    logic [1:0]    s_r_resp;
    logic          s_r_valid, s_r_ready;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0] wr_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    axi_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_regs [NR];
    bit          m_aw_have, m_w_have, m_b_pend, m_r_pend, model_live = 0;
    logic [31:0] m_aw_addr, m_w_data, m_r_data;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;
    logic [NR-1:0] m_pulse;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_r_pend = 0;
            m_pulse = '0; model_live = 1;
        end else begin
            // reads see the register file as it was before this edge's write
            if (m_r_pend) begin
                if (s_r_ready) m_r_pend = 0;
            end else if (s_ar_valid) begin
                m_r_pend = 1;
                if ((s_ar_addr >> 2) < NR) begin
                    m_r_data = m_regs[s_ar_addr >> 2];
                    m_r_resp = 2'b00;
                end else begin
                    m_r_data = '0;
                    m_r_resp = 2'b10;
                end
            end
            m_pulse = '0;
            if (m_b_pend) begin
                if (s_b_ready) m_b_pend = 0;
            end else if (m_aw_have && m_w_have) begin
                if ((m_aw_addr >> 2) < NR) begin
                    for (int b = 0; b < 4; b++)
                        if (m_w_strb[b]) m_regs[m_aw_addr >> 2][b*8 +: 8] = m_w_data[b*8 +: 8];
                    m_pulse[m_aw_addr >> 2] = 1'b1;
                    m_b_resp = 2'b00;
                end else begin
                    m_b_resp = 2'b10;
                end
                m_b_pend = 1; m_aw_have = 0; m_w_have = 0;
            end else begin
                if (!m_aw_have && s_aw_valid) begin m_aw_have = 1; m_aw_addr = s_aw_addr; end
                if (!m_w_have && s_w_valid) begin
                    m_w_have = 1; m_w_data = s_w_data; m_w_strb = s_w_strb;
                end
            end
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (model_live) begin
            logic [NR*32-1:0] packed_regs;
            for (int i = 0; i < NR; i++) packed_regs[i*32 +: 32] = m_regs[i];
            chk("reg_q", reg_q, packed_regs);
            chk("wr_pulse", wr_pulse, m_pulse);
            chk("aw_ready", s_aw_ready, !m_b_pend && !m_aw_have);
            chk("w_ready", s_w_ready, !m_b_pend && !m_w_have);
            chk("b_valid", s_b_valid, m_b_pend);
            chk("ar_ready", s_ar_ready, !m_r_pend);
            chk("r_valid", s_r_valid, m_r_pend);
            if (m_b_pend) chk("b_resp", s_b_resp, m_b_resp);
            if (m_r_pend) begin
                chk("r_data", s_r_data, m_r_data);
                chk("r_resp", s_r_resp, m_r_resp);
            end
        end
    end

    // Record wr_pulse activity for the directed literal checks.
    logic [NR-1:0] pulse_seen;
    int            pulse_cycles;
    always @(negedge clk) begin
        if (|wr_pulse) begin pulse_seen = wr_pulse; pulse_cycles++; end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int stall);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, b_done = 0;
        stall = 0;
        resp  = 2'b01;
        while (!b_done && cyc < 100) begin
            s_aw_valid = !aw_done && (cyc >= aw_dly);
            s_aw_addr  = addr;
            s_w_valid  = !w_done && (cyc >= w_dly);
            s_w_data   = data;
            s_w_strb   = strb;
            s_b_ready  = (stall >= b_dly);
            @(negedge clk);
            if (s_aw_valid && s_aw_ready) aw_done = 1;
            if (s_w_valid && s_w_ready) w_done = 1;
            if (s_b_valid) begin
                if (s_b_ready) begin b_done = 1; resp = s_b_resp; end
                else stall++;
            end
            tick();
            cyc++;
        end
        s_aw_valid = 0; s_w_valid = 0; s_b_ready = 0;
        if (!b_done) begin
            n_cmp++; n_fail++;
            $display("FAIL write_timeout: addr %h got no B response, required one within 100 cycles", addr);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int a_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0, rc = 0;
        bit a_done = 0, r_done = 0;
        data = 'x;
        resp = 2'b01;
        while (!r_done && cyc < 100) begin
            s_ar_valid = !a_done && (cyc >= a_dly);
            s_ar_addr  = addr;
            s_r_ready  = (rc >= r_dly);
            @(negedge clk);
            if (s_ar_valid && s_ar_ready) a_done = 1;
            if (s_r_valid) begin
                if (s_r_ready) begin r_done = 1; data = s_r_data; resp = s_r_resp; end
                else rc++;
            end
            tick();
            cyc++;
        end
        s_ar_valid = 0; s_r_ready = 0;
        if (!r_done) begin
            n_cmp++; n_fail++;
            $display("FAIL read_timeout: addr %h got no R response, required one within 100 cycles", addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [NR*32-1:0] snap;
        int stall;
        int bcount;

        rst = 1;
        s_aw_addr = '0; s_aw_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_valid = 0;
        s_b_ready = 0; s_ar_addr = '0; s_ar_valid = 0; s_r_ready = 0;
        pulse_cycles = 0; pulse_seen = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_reg_q", reg_q, '0);
        chk("reset_ready", {s_aw_ready, s_w_ready, s_ar_ready}, 3'b111);
        chk("reset_valid", {s_b_valid, s_r_valid}, 2'b00);
        chk("reset_resp_data", {s_b_resp, s_r_resp, s_r_data}, '0);
        rst = 0;
        tick();

        // AW leads W by two cycles, full strobe
        pulse_cycles = 0;
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 2, 0, resp, stall);
        chk("w1_resp", resp, 2'b00);
        chk("w1_reg1", reg_q[63:32], 32'hDEADBEEF);
        chk("w1_pulse", pulse_seen, 8'b0000_0010);
        chk("w1_pulse_len", pulse_cycles, 1);

        // W leads AW, low two bytes only
        do_write(32'h4, 32'h12345678, 4'h3, 2, 0, 0, resp, stall);
        chk("w2_reg1", reg_q[63:32], 32'hDEAD5678);

        // out-of-range write and read
        snap = reg_q;
        pulse_cycles = 0;
        do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, stall);
        chk("w3_resp", resp, 2'b10);
        chk("w3_no_change", reg_q, snap);
        chk("w3_no_pulse", pulse_cycles, 0);
        do_read(32'h20, 0, 0, rdata, resp);
        chk("r3_data", rdata, 32'h0);
        chk("r3_resp", resp, 2'b10);
        do_read(32'h5, 1, 2, rdata, resp);
        chk("r4_data", rdata, 32'hDEAD5678);

        // B back-pressure for five cycles
        do_write(32'h8, 32'hA5A50F0F, 4'hF, 0, 0, 5, resp, stall);
        chk("w5_stall", stall, 5);
        chk("w5_resp", resp, 2'b00);
        chk("w5_reg2", reg_q[95:64], 32'hA5A50F0F);

        // AR sampled on the same edge as a commit to the same register
        s_b_ready = 1; s_r_ready = 1;
        s_aw_valid = 1; s_aw_addr = 32'h4; s_w_valid = 1; s_w_data = 32'h0; s_w_strb = 4'hF;
        tick();
        s_aw_valid = 0; s_w_valid = 0; s_ar_valid = 1; s_ar_addr = 32'h4;
        tick();
        s_ar_valid = 0;
        @(negedge clk);
        chk("rw_r_valid", s_r_valid, 1'b1);
        chk("rw_r_data", s_r_data, 32'hDEAD5678);
        chk("rw_reg1", reg_q[63:32], 32'h0);
        tick();
        s_b_ready = 0; s_r_ready = 0;

        // reset while a B response is pending
        s_aw_valid = 1; s_aw_addr = 32'h8; s_w_valid = 1; s_w_data = 32'h55; s_w_strb = 4'hF;
        tick();
        s_aw_valid = 0; s_w_valid = 0;
        tick();
        @(negedge clk);
        chk("rst_pre_b_valid", s_b_valid, 1'b1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_b_valid", s_b_valid, 1'b0);
        chk("rst_reg_q", reg_q, '0);
        chk("rst_pulse_resp", {wr_pulse, s_b_resp, s_r_resp, s_r_valid}, '0);
        chk("rst_ready", {s_aw_ready, s_w_ready, s_ar_ready}, 3'b111);
        rst = 0;
        s_b_ready = 1;
        bcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_b_valid) bcount++;
        end
        chk("rst_no_b", bcount, 0);
        tick();
        s_b_ready = 0;

        // randomized concurrent traffic; the per-cycle compare checks everything
        fork
            begin
                logic [1:0] wr_resp;
                int         wr_stall;
                for (int k = 0; k < 50; k++)
                    do_write($urandom_range(0, 39), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                             wr_resp, wr_stall);
            end
            begin
                logic [31:0] rd_data;
                logic [1:0]  rd_resp;
                for (int k = 0; k < 50; k++)
                    do_read($urandom_range(0, 39), $urandom_range(0, 3), $urandom_range(0, 3),
                            rd_data, rd_resp);
            end
        join

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width; a multiple of 8.
REQ-003 Parameter NUM_REGS, default 8: number of DATA_WIDTH registers; at least 1.
REQ-004 Port clk  in  1: single clock; all logic on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Ports s_aw_addr in ADDR_WIDTH; s_aw_valid in 1; s_aw_ready out 1: write address channel.
REQ-007 Ports s_w_data in DATA_WIDTH; s_w_strb in DATA_WIDTH/8; s_w_valid in 1; s_w_ready out 1: write data channel.
REQ-008 Ports s_b_resp out 2; s_b_valid out 1; s_b_ready in 1: write response channel.
REQ-009 Ports s_ar_addr in ADDR_WIDTH; s_ar_valid in 1; s_ar_ready out 1: read address channel.
REQ-010 Ports s_r_data out DATA_WIDTH; s_r_resp out 2; s_r_valid out 1; s_r_ready in 1: read data channel.
REQ-011 Port reg_q  out  NUM_REGS*DATA_WIDTH: packed register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Port wr_pulse  out  NUM_REGS: one-cycle strobe per register on every committed OKAY write.

Function
REQ-013 Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; index < NUM_REGS -> OKAY (2'b00); index >= NUM_REGS -> SLVERR (2'b10); low byte-offset bits ignored.
REQ-014 Write FSM states: W_IDLE, W_RESP.
REQ-015 In W_IDLE: s_aw_ready = !aw_held and s_w_ready = !w_held; AW and W are each captured on their own handshake, in either order or in the same cycle.
REQ-016 Once both are held, at the next edge: commit the write, pulse wr_pulse[idx] for one cycle, clear both held flags, enter W_RESP.
REQ-017 Commit updates only bytes with s_w_strb=1; SLVERR writes change no register and produce no wr_pulse.
REQ-018 In W_RESP: s_b_valid=1; s_b_resp stable; s_aw_ready=s_w_ready=0; on s_b_valid && s_b_ready, return to W_IDLE at the next edge.
REQ-019 Read FSM states: R_IDLE (s_ar_ready=1), R_RESP (s_ar_ready=0, s_r_valid=1).
REQ-020 On the AR handshake, register s_r_data and s_r_resp; SLVERR reads return data 0; both are held until s_r_ready.
REQ-021 Read and write paths are independent; each has one outstanding transaction maximum.
REQ-022 A read and a write commit to the same register at the same edge: the read returns the pre-write value.
REQ-023 Valid inputs are never combinationally gated by ready; no output depends combinationally on any input.

Reset
REQ-024 While rst=1 at an edge: all registers 0; both FSMs in IDLE; held flags 0; s_b_valid=s_r_valid=0; s_b_resp=s_r_resp=0; s_r_data=0; wr_pulse=0.
REQ-025 After reset: s_aw_ready=s_w_ready=s_ar_ready=1.
REQ-026 Reset mid-transaction discards the transaction silently; no response is issued for it afterwards.

Structure
REQ-027 The shared axi_lite_pkg holds response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11) and the write/read FSM state enums.
REQ-028 One sub-module, axi_lite_strb_merge (combinational byte-strobe merge of old data and new data), is used per write commit.

Verification
REQ-029 Write addr 0x4, data 0xDEADBEEF, strb 0xF, AW before W by 2 cycles -> B OKAY; reg_q[63:32]=0xDEADBEEF; wr_pulse=8'b0000_0010 for one cycle.
REQ-030 W before AW, strb 0x3, data 0x12345678 to addr 0x4 (prior value 0xDEADBEEF) -> reg1=0xDEAD5678.
REQ-031 Write addr 0x20 (index 8) -> B SLVERR; no reg_q change; wr_pulse=0. Read addr 0x20 -> r_data=0, r_resp=SLVERR.
REQ-032 Hold s_b_ready=0 for 5 cycles -> s_b_valid and s_b_resp stable; s_aw_ready=s_w_ready=0 throughout.
REQ-033 AR to addr 0x4 at the same edge as a write commit of 0x0 to reg1 -> r_data=0xDEAD5678.
REQ-034 Assert rst while in W_RESP -> outputs match REQ-024 at the next edge; no B handshake follows.
